spi_burst_ctrl: RTL and testbench
=================================

# spi_burst_ctrl

Byte-burst controller that sits directly upstream of the SPI `top` block and drives its `enable`, `master_in` and `mode` inputs. Software or a host FSM queues bytes in a TX FIFO, then pulses `start`. The block holds chip-select low and feeds the bytes one at a time to the SPI engine. It collects each returned byte into an RX FIFO for the consumer.

## Interface
Parameters:
- `DEPTH`, 8, entries per FIFO; power of two, 2..64
- `GAP_CYCLES`, 2, idle clocks between consecutive bytes of a burst; 0..15

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `wr_valid`  in  1  TX FIFO push request
- `wr_data`  in  8  TX byte
- `wr_ready`  out  1  TX FIFO not full
- `start`  in  1  single-cycle burst request
- `mode_in`  in  3  SPI mode, captured on accepted `start`
- `busy`  out  1  burst in progress (state ≠ IDLE)
- `burst_done`  out  1  single-cycle pulse at end of burst
- `rd_valid`  out  1  RX FIFO not empty
- `rd_data`  out  8  RX FIFO head byte
- `rd_ready`  in  1  RX FIFO pop
- `spi_enable`  out  1  to SPI `enable`
- `spi_tx`  out  8  to SPI `master_in`
- `spi_mode`  out  3  to SPI `mode`
- `spi_done`  in  1  single-cycle pulse from SPI engine: byte complete
- `spi_rx`  in  8  received byte; valid while `spi_done` is high
- `cs_n`  out  1  slave select, active low

## Operation
- Push happens when `wr_valid && wr_ready`. Pop happens when `rd_valid && rd_ready`. `rd_data` is first-word fall-through.
- FSM states are IDLE, SETUP, XFER, GAP and FINISH.
- IDLE: `start` is accepted only if the TX FIFO is non-empty. Otherwise it is ignored, with no `burst_done` pulse. On accept, capture `mode_in` into `spi_mode` and go to SETUP.
- SETUP, one cycle: pop the TX head into the `spi_tx` register and drive `cs_n`=0. Go to XFER.
- XFER: hold `spi_enable`=1 and `spi_tx` stable until `spi_done`.
  - On `spi_done`, push `spi_rx` into the RX FIFO.
  - If the TX FIFO is empty at that cycle, go to FINISH. Otherwise go to GAP.
- GAP:
  - Count `GAP_CYCLES` clocks with `spi_enable`=0 and `cs_n` held low.
  - Then, if the RX FIFO is not full, go to SETUP. If it is full, stay in GAP until it is not full.
  - With `GAP_CYCLES`=0, the count is skipped but the RX-full check still applies.
- FINISH, one cycle: `cs_n`=1, `spi_enable`=0 and `burst_done`=1. Go to IDLE.
- Bytes pushed during a burst extend it if they arrive before the TX-empty check at `spi_done`.
- `spi_done` outside XFER is ignored; nothing is pushed.
- `start` while `busy` is ignored.
- The RX FIFO can never overflow, because SETUP is entered only with at least one free RX slot.
- FIFO boundaries:
  - A push to a full FIFO is blocked, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers are log2(`DEPTH`)+1 bits and wrap naturally.
- Reset, including mid-burst, forces:
  - state = IDLE
  - both FIFOs empty
  - `cs_n`=1, `spi_enable`=0, `spi_tx`=0, `spi_mode`=0
  - `busy`=0, `burst_done`=0
  - `wr_ready`=1, `rd_valid`=0

## Timing
- Accepted `start` at edge N:
  - SETUP in cycle N+1, with `cs_n` falling.
  - XFER from N+2, with `spi_enable` high and `spi_tx` valid.
- `spi_done` sampled at edge M:
  - `rd_valid` is high from M+1.
  - GAP or FINISH begins at M+1.
- Next-byte `spi_enable` rises `GAP_CYCLES`+2 cycles after the previous `spi_done`, provided the RX FIFO is not full.
- After the last byte's `spi_done` at M:
  - `burst_done` is high in cycle M+1.
  - `cs_n` rises at M+1.
  - `busy` falls at M+2.
- All outputs are registered except `wr_ready`, `rd_valid` and `rd_data`, which decode directly from FIFO state.

## Structure
- Package `spi_pkg` holds:
  - `SPI_BYTE_W`=8
  - `SPI_MODE_W`=3
  - the FSM state enum `burst_state_t`
- Sub-module `sync_fifo`, parameterised on width and depth with async active-high reset, is instantiated twice (TX and RX).
- The FSM, gap counter and SPI-side registers live in `spi_burst_ctrl`.

## Test plan
- Push 0xAA, 0x55, 0x0F; `start` with `mode_in`=3'b001; the SPI model echoes inverted bytes.
  - Expect `cs_n` low across all three transfers with 2-cycle gaps.
  - Expect RX to read 0x55, 0xAA, 0xF0.
  - Expect exactly one `burst_done` pulse.
- `start` with an empty TX FIFO: `busy` stays 0 and there is no `burst_done` pulse. Then a `start` while busy mid-burst has no effect.
- Run with `DEPTH`=4: push 6 bytes.
  - `wr_ready` drops after 4 pushes.
  - Run a burst without popping RX. After 4 RX bytes, the FSM holds in GAP with `cs_n`=0.
  - A single pop resumes the burst.
- Assert `reset` during XFER of byte 2.
  - The next cycle shows `cs_n`=1, `spi_enable`=0, `rd_valid`=0 and `wr_ready`=1.
  - A fresh burst afterwards works normally.
- Push 1 byte and `start`; push 0x3C during that byte's XFER. The burst covers 2 bytes, and `burst_done` pulses after the second `spi_done`.
- With `GAP_CYCLES`=0, consecutive `spi_enable` pulses are separated by exactly 1 low cycle (the SETUP cycle).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared widths and FSM state encoding for the SPI burst controller.
package spi_pkg;
    localparam int SPI_BYTE_W = 8;
    localparam int SPI_MODE_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_GAP,
        ST_FINISH
    } burst_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             full, empty, do_push, do_pop;

    // Extra MSB on each pointer distinguishes full from empty.
    assign count   = wptr - rptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst controller: streams queued TX bytes through the SPI engine under one
// chip-select assertion and collects the returned bytes into an RX FIFO.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [SPI_BYTE_W-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  start,
    input  logic [SPI_MODE_W-1:0] mode_in,
    output logic                  busy,
    output logic                  burst_done,
    output logic                  rd_valid,
    output logic [SPI_BYTE_W-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  spi_enable,
    output logic [SPI_BYTE_W-1:0] spi_tx,
    output logic [SPI_MODE_W-1:0] spi_mode,
    input  logic                  spi_done,
    input  logic [SPI_BYTE_W-1:0] spi_rx,
    output logic                  cs_n
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [3:0]  GAP_LOAD = 4'(GAP_CYCLES);

    burst_state_t          state;
    logic [3:0]            gap_cnt;
    logic [AW:0]           tx_count, rx_count;
    logic [SPI_BYTE_W-1:0] tx_head;
    logic                  tx_empty, rx_full, rx_push;

    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign wr_ready = (tx_count != FULL_CNT);
    assign rd_valid = (rx_count != '0);
    assign rx_push  = (state == ST_XFER) && spi_done;

    sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (state == ST_SETUP),
        .head      (tx_head),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (spi_rx),
        .pop       (rd_ready),
        .head      (rd_data),
        .count     (rx_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            cs_n       <= 1'b1;
            spi_enable <= 1'b0;
            spi_tx     <= '0;
            spi_mode   <= '0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !tx_empty) begin
                        spi_mode <= mode_in;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    spi_tx     <= tx_head;
                    spi_enable <= 1'b1;
                    state      <= ST_XFER;
                end
                ST_XFER: begin
                    if (spi_done) begin
                        spi_enable <= 1'b0;
                        if (tx_empty) begin
                            cs_n       <= 1'b1;
                            burst_done <= 1'b1;
                            state      <= ST_FINISH;
                        end else if (GAP_CYCLES == 0 && rx_count < LAST_CNT) begin
                            // Zero gap and RX still has room after this push.
                            state <= ST_SETUP;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt > 4'd1) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else begin
                        // Count expired: wait here for the consumer to free an RX slot.
                        gap_cnt <= '0;
                        if (!rx_full) state <= ST_SETUP;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench: DUT a (DEPTH=4, GAP=2) and DUT b (DEPTH=8, GAP=0), each with an inverting SPI echo model.
module tb_spi_burst_ctrl;
    logic clk, reset;

    logic       wr_valid_a, wr_ready_a, start_a, busy_a, burst_done_a, rd_valid_a, rd_ready_a;
    logic       spi_enable_a, spi_done_a, cs_n_a;
    logic [7:0] wr_data_a, rd_data_a, spi_tx_a, spi_rx_a;
    logic [2:0] mode_in_a, spi_mode_a;

    logic       wr_valid_b, wr_ready_b, start_b, busy_b, burst_done_b, rd_valid_b, rd_ready_b;
    logic       spi_enable_b, spi_done_b, cs_n_b;
    logic [7:0] wr_data_b, rd_data_b, spi_tx_b, spi_rx_b;
    logic [2:0] mode_in_b, spi_mode_b;

    spi_burst_ctrl #(.DEPTH(4), .GAP_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .wr_valid(wr_valid_a), .wr_data(wr_data_a), .wr_ready(wr_ready_a),
        .start(start_a), .mode_in(mode_in_a), .busy(busy_a), .burst_done(burst_done_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
        .spi_enable(spi_enable_a), .spi_tx(spi_tx_a), .spi_mode(spi_mode_a),
        .spi_done(spi_done_a), .spi_rx(spi_rx_a), .cs_n(cs_n_a)
    );

    spi_burst_ctrl #(.DEPTH(8), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .wr_valid(wr_valid_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b),
        .start(start_b), .mode_in(mode_in_b), .busy(busy_b), .burst_done(burst_done_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
        .spi_enable(spi_enable_b), .spi_tx(spi_tx_b), .spi_mode(spi_mode_b),
        .spi_done(spi_done_b), .spi_rx(spi_rx_b), .cs_n(cs_n_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SPI engine models: done pulse on the third enabled clock, returning ~tx.
    logic [1:0] cnt_a, cnt_b;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a <= '0; spi_done_a <= 1'b0; spi_rx_a <= '0;
        end else if (spi_done_a) begin
            spi_done_a <= 1'b0;
        end else if (spi_enable_a) begin
            if (cnt_a == 2'd2) begin
                spi_done_a <= 1'b1; spi_rx_a <= ~spi_tx_a; cnt_a <= '0;
            end else cnt_a <= cnt_a + 2'd1;
        end
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_b <= '0; spi_done_b <= 1'b0; spi_rx_b <= '0;
        end else if (spi_done_b) begin
            spi_done_b <= 1'b0;
        end else if (spi_enable_b) begin
            if (cnt_b == 2'd2) begin
                spi_done_b <= 1'b1; spi_rx_b <= ~spi_tx_b; cnt_b <= '0;
            end else cnt_b <= cnt_b + 2'd1;
        end
    end

    int n_tests = 0, n_fail = 0;
    logic [7:0] sb_a[$], sb_b[$];
    int gaps_a[$], gaps_b[$];
    int bd_a = 0, bd_b = 0, done_a = 0, done_b = 0, cs_bad_a = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // RX monitors: compare every popped byte against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rd_valid_a && rd_ready_a) begin
            if (sb_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rx_a_unexpected: got %0h, expected nothing", rd_data_a);
            end else chk("rx_a_data", 32'(rd_data_a), 32'(sb_a.pop_front()));
        end
        if (rd_valid_b && rd_ready_b) begin
            if (sb_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rx_b_unexpected: got %0h, expected nothing", rd_data_b);
            end else chk("rx_b_data", 32'(rd_data_b), 32'(sb_b.pop_front()));
        end
    end

    // Event counters and inter-byte gap measurement (low enable cycles inside a burst).
    initial begin
        int run_a = 0, run_b = 0;
        bit had_a = 0, had_b = 0;
        forever begin
            @(negedge clk);
            if (burst_done_a) bd_a++;
            if (burst_done_b) bd_b++;
            if (spi_done_a && spi_enable_a) done_a++;
            if (spi_done_b && spi_enable_b) done_b++;
            if (busy_a && cs_n_a && !burst_done_a) cs_bad_a++;
            if (!busy_a) begin had_a = 0; run_a = 0; end
            else if (spi_enable_a) begin
                if (had_a && run_a != 0) gaps_a.push_back(run_a);
                had_a = 1; run_a = 0;
            end else run_a++;
            if (!busy_b) begin had_b = 0; run_b = 0; end
            else if (spi_enable_b) begin
                if (had_b && run_b != 0) gaps_b.push_back(run_b);
                had_b = 1; run_b = 0;
            end else run_b++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_a(input logic [7:0] d);
        int n = 0;
        while (!wr_ready_a && n < 300) begin tick(); n++; end
        if (!wr_ready_a) begin n_tests++; n_fail++; $display("FAIL push_a_timeout: wr_ready 0, expected 1"); end
        wr_valid_a = 1'b1; wr_data_a = d;
        tick();
        wr_valid_a = 1'b0;
        sb_a.push_back(~d);
    endtask

    task automatic push_b(input logic [7:0] d);
        wr_valid_b = 1'b1; wr_data_b = d;
        tick();
        wr_valid_b = 1'b0;
        sb_b.push_back(~d);
    endtask

    task automatic pulse_start_a(input logic [2:0] m);
        start_a = 1'b1; mode_in_a = m;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input string nm);
        int n = 0;
        while (done_a < target && n < 500) begin tick(); n++; end
        chk(nm, 32'(done_a), 32'(target));
    endtask

    task automatic wait_bd_a(input string nm);
        int n = 0;
        while (!burst_done_a && n < 500) begin tick(); n++; end
        chk(nm, 32'(burst_done_a), 32'd1);
    endtask

    initial begin
        int base, bdb;
        reset = 1'b1;
        {wr_valid_a, start_a, rd_ready_a, wr_valid_b, start_b} = '0;
        rd_ready_b = 1'b1;
        wr_data_a = '0; mode_in_a = '0; wr_data_b = '0; mode_in_b = '0;
        tick(3);
        chk("rst_cs_n", 32'(cs_n_a), 32'd1);
        chk("rst_spi_enable", 32'(spi_enable_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready_a), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid_a), 32'd0);
        chk("rst_spi_tx_mode", 32'({spi_tx_a, spi_mode_a}), 32'd0);
        reset = 1'b0;
        tick();

        // start with empty TX is ignored
        bdb = bd_a;
        pulse_start_a(3'd3);
        tick(4);
        chk("empty_start_busy", 32'(busy_a), 32'd0);
        chk("empty_start_cs_n", 32'(cs_n_a), 32'd1);
        chk("empty_start_no_done", 32'(bd_a - bdb), 32'd0);

        // three-byte burst, inverted echo, 2-cycle gaps
        rd_ready_a = 1'b1;
        gaps_a.delete(); bdb = bd_a; cs_bad_a = 0;
        push_a(8'hAA); push_a(8'h55); push_a(8'h0F);
        pulse_start_a(3'b001);
        chk("setup_cs_n", 32'(cs_n_a), 32'd0);
        chk("setup_busy", 32'(busy_a), 32'd1);
        chk("setup_enable", 32'(spi_enable_a), 32'd0);
        tick();
        chk("xfer_enable", 32'(spi_enable_a), 32'd1);
        chk("xfer_tx", 32'(spi_tx_a), 32'hAA);
        chk("xfer_mode", 32'(spi_mode_a), 32'd1);
        pulse_start_a(3'b110);
        chk("busy_start_mode", 32'(spi_mode_a), 32'd1);
        wait_bd_a("burst1_done");
        chk("finish_cs_n", 32'(cs_n_a), 32'd1);
        chk("finish_busy", 32'(busy_a), 32'd1);
        tick();
        chk("idle_busy", 32'(busy_a), 32'd0);
        chk("idle_burst_done", 32'(burst_done_a), 32'd0);
        tick(3);
        chk("burst1_one_pulse", 32'(bd_a - bdb), 32'd1);
        chk("burst1_cs_held", 32'(cs_bad_a), 32'd0);
        chk("burst1_gap_cnt", 32'(gaps_a.size()), 32'd2);
        foreach (gaps_a[i]) chk("burst1_gap_len", 32'(gaps_a[i]), 32'd3);
        chk("burst1_sb_empty", 32'(sb_a.size()), 32'd0);

        // DEPTH=4 backpressure: TX full, RX full holds in GAP
        rd_ready_a = 1'b0;
        bdb = bd_a;
        push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
        chk("tx_full_wr_ready", 32'(wr_ready_a), 32'd0);
        wr_valid_a = 1'b1; wr_data_a = 8'h99;
        tick();
        wr_valid_a = 1'b0;
        base = done_a;
        pulse_start_a(3'd0);
        push_a(8'h55); push_a(8'h66);
        wait_done_a(base + 4, "rxfull_4_bytes");
        tick(15);
        chk("rxfull_hold_cs_n", 32'(cs_n_a), 32'd0);
        chk("rxfull_hold_enable", 32'(spi_enable_a), 32'd0);
        chk("rxfull_hold_busy", 32'(busy_a), 32'd1);
        chk("rxfull_hold_count", 32'(done_a), 32'(base + 4));
        rd_ready_a = 1'b1;
        tick();
        rd_ready_a = 1'b0;
        wait_done_a(base + 5, "rxfull_resume");
        rd_ready_a = 1'b1;
        wait_bd_a("rxfull_burst_done");
        tick(4);
        chk("rxfull_total", 32'(done_a), 32'(base + 6));
        chk("rxfull_one_pulse", 32'(bd_a - bdb), 32'd1);
        chk("rxfull_sb_empty", 32'(sb_a.size()), 32'd0);

        // reset during byte 2 transfer
        push_a(8'hA1); push_a(8'hB2); push_a(8'hC3);
        base = done_a;
        pulse_start_a(3'd2);
        wait_done_a(base + 1, "rst_mid_byte1");
        begin
            int n = 0;
            while (!spi_enable_a && n < 50) begin tick(); n++; end
        end
        chk("rst_mid_in_xfer", 32'(spi_enable_a), 32'd1);
        reset = 1'b1;
        tick();
        sb_a.delete();
        chk("rst_mid_cs_n", 32'(cs_n_a), 32'd1);
        chk("rst_mid_enable", 32'(spi_enable_a), 32'd0);
        chk("rst_mid_rd_valid", 32'(rd_valid_a), 32'd0);
        chk("rst_mid_wr_ready", 32'(wr_ready_a), 32'd1);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;
        tick();
        bdb = bd_a;
        push_a(8'h12); push_a(8'h34);
        pulse_start_a(3'd4);
        wait_bd_a("post_rst_done");
        tick(3);
        chk("post_rst_one_pulse", 32'(bd_a - bdb), 32'd1);
        chk("post_rst_sb_empty", 32'(sb_a.size()), 32'd0);

        // byte pushed during XFER extends the burst
        bdb = bd_a; base = done_a;
        push_a(8'hC3);
        pulse_start_a(3'd0);
        begin
            int n = 0;
            while (!spi_enable_a && n < 50) begin tick(); n++; end
        end
        push_a(8'h3C);
        wait_bd_a("extend_done");
        chk("extend_bytes", 32'(done_a - base), 32'd2);
        tick(3);
        chk("extend_one_pulse", 32'(bd_a - bdb), 32'd1);
        chk("extend_sb_empty", 32'(sb_a.size()), 32'd0);

        // GAP_CYCLES=0: one low enable cycle between bytes
        gaps_b.delete();
        push_b(8'h01); push_b(8'h02); push_b(8'h03);
        start_b = 1'b1; mode_in_b = 3'd5;
        tick();
        start_b = 1'b0;
        begin
            int n = 0;
            while (!burst_done_b && n < 500) begin tick(); n++; end
        end
        chk("gap0_done", 32'(burst_done_b), 32'd1);
        tick(3);
        chk("gap0_gap_cnt", 32'(gaps_b.size()), 32'd2);
        foreach (gaps_b[i]) chk("gap0_gap_len", 32'(gaps_b[i]), 32'd1);
        chk("gap0_sb_empty", 32'(sb_b.size()), 32'd0);
        chk("gap0_one_pulse", 32'(bd_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
